booth_divider_seq: RTL and testbench

BOOTH_DIVIDER_SEQ -- requirements
Module: booth_divider_seq

---
 rtl/booth_divider_seq.sv | 120 ++++++++++++
 tb/tb_booth_divider_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_divider_seq.sv
// Sequential signed divider: 2N-bit dividend / N-bit divisor by restoring shift-subtract.
// Define BOOTH_DIVIDER_SATURATE_EN to clamp the quotient on overflow instead of wrapping it.
module booth_divider_seq #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           busy,
   output logic           done,
   output logic [N-1:0]   quotient,
   output logic [N-1:0]   remainder,
   output logic           overflow,
   output logic           div_by_zero
);

   localparam int CNT_W = $clog2(2*N);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(2*N-1);
   localparam logic [2*N-1:0]   QPOS_LIM  = {{(N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic [2*N-1:0]   QNEG_LIM  = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2*N-1:0]   r_q;
   logic [N-1:0]     r_rem;
   logic [N-1:0]     r_dvs;
   logic [N-1:0]     r_dvd_lo;
   logic             r_sd;
   logic             r_sv;
   logic             r_zero;

   function automatic logic [N-1:0] f_sign_apply(input logic [N-1:0] mag, input logic neg);
      return neg ? -mag : mag;
   endfunction

`ifdef BOOTH_DIVIDER_SATURATE_EN
   function automatic logic [N-1:0] f_sat(input logic neg);
      return neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
   endfunction
`endif

   logic [N:0]   w_trial;
   logic         w_fits;
   logic         w_qneg;
   logic         w_ovf;
   logic [N-1:0] w_q_wrap;
   logic [N-1:0] w_q_fix;
   logic [N-1:0] w_r_fix;

   // Partial remainder stays below |divisor| <= 2^(N-1), so N+1 bits hold the shifted trial value
   assign w_trial  = {r_rem, r_q[2*N-1]} - {1'b0, r_dvs};
   assign w_fits   = ~w_trial[N];

   assign w_qneg   = (r_sd ^ r_sv) && (r_q != '0);
   assign w_ovf    = !r_zero && (w_qneg ? (r_q > QNEG_LIM) : (r_q > QPOS_LIM));
   assign w_q_wrap = f_sign_apply(r_q[N-1:0], w_qneg);
`ifdef BOOTH_DIVIDER_SATURATE_EN
   assign w_q_fix  = w_ovf ? f_sat(w_qneg) : w_q_wrap;
`else
   assign w_q_fix  = w_q_wrap;
`endif
   assign w_r_fix  = r_zero ? r_dvd_lo : f_sign_apply(r_rem, r_sd);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         overflow    <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_q      <= dividend[2*N-1] ? -dividend : dividend;
                  r_dvs    <= divisor[N-1] ? -divisor : divisor;
                  r_dvd_lo <= dividend[N-1:0];
                  r_sd     <= dividend[2*N-1];
                  r_sv     <= divisor[N-1];
                  r_zero   <= (divisor == '0);
                  r_rem    <= '0;
                  r_cnt    <= LAST_ITER;
                  busy     <= 1'b1;
                  r_state  <= S_CALC;
               end
            end
            S_CALC: begin
               r_q   <= {r_q[2*N-2:0], w_fits};
               r_rem <= w_fits ? w_trial[N-1:0] : {r_rem[N-2:0], r_q[2*N-1]};
               if (r_cnt == '0) begin
                  r_state <= S_FIX;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_FIX: begin
               quotient    <= r_zero ? '0 : w_q_fix;
               remainder   <= w_r_fix;
               overflow    <= w_ovf;
               div_by_zero <= r_zero;
               done        <= 1'b1;
               busy        <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_divider_seq.sv
// Scoreboard bench for booth_divider_seq: driver queues expected results from an
// arithmetic reference model, an independent monitor checks every done pulse.
module tb_booth_divider_seq;

   localparam int N   = 8;
   localparam int LAT = 2*N + 1;   // edges after the accepting edge (18 counting it)

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [2*N-1:0] dividend;
   logic [N-1:0]   divisor;
   logic           busy;
   logic           done;
   logic [N-1:0]   quotient;
   logic [N-1:0]   remainder;
   logic           overflow;
   logic           div_by_zero;

   booth_divider_seq #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .overflow(overflow), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         ovf;
      logic         dbz;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   logic prev_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain signed integer division, truncating toward zero
   function automatic exp_t model(input logic [2*N-1:0] x, input logic [N-1:0] y);
      exp_t   e;
      longint a, b, qv, rv, lim;
      a   = longint'($signed(x));
      b   = longint'($signed(y));
      lim = longint'(1) << (N-1);
      e.acc = 0;
      if (b == 0) begin
         e.q = '0; e.r = x[N-1:0]; e.ovf = 1'b0; e.dbz = 1'b1;
      end else begin
         qv    = a / b;
         rv    = a % b;
         e.ovf = (qv > lim - 1) || (qv < -lim);
         e.dbz = 1'b0;
         e.q   = qv[N-1:0];
`ifdef BOOTH_DIVIDER_SATURATE_EN
         if (e.ovf) e.q = (qv < 0) ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
         e.r   = rv[N-1:0];
      end
      return e;
   endfunction

   // Monitor
   always @(negedge clk) begin
      if (done === 1'b1) begin
         exp_t e;
         chk("done_pulse_width", prev_done, 0);
         if (sb.size() == 0) begin
            chk("spurious_done", done, 0);
         end else begin
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("overflow", overflow, e.ovf);
            chk("div_by_zero", div_by_zero, e.dbz);
            chk("latency", cyc - e.acc, LAT);
         end
      end
      prev_done <= (done === 1'b1);
   end

   // Called at a negedge while the DUT is idle (or in its done cycle)
   task automatic issue(input logic [2*N-1:0] a, input logic [N-1:0] b, input bit push);
      exp_t e;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (push) begin
         e     = model(a, b);
         e.acc = cyc;
         sb.push_back(e);
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 4*LAT; i++) begin
         @(negedge clk);
         if (done === 1'b1) return;
      end
      chk("done_timeout", done, 1);
   endtask

   task automatic run(input logic [2*N-1:0] a, input logic [N-1:0] b);
      issue(a, b, 1'b1);
      wait_done();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2*N-1:0] ra;
      logic [N-1:0]   rb;
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_dbz", div_by_zero, 0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases, issued back-to-back in each done cycle
      run(16'sd15, 8'sd3);
      chk("busy_after_done", busy, 0);
      run(-16'sd17, 8'sd3);
      run(16'sd17, -8'sd3);
      run(16'sd128, -8'sd1);
      run(-16'sd32768, -8'sd1);
      run(16'sd1000, 8'sd2);
      run(16'sd300, 8'sd0);
      run(-16'sd300, 8'sd0);
      run(16'sd32767, -8'sd128);
      run(-16'sd32768, -8'sd128);
      run(-16'sd16384, -8'sd128);
      run(16'sd0, -8'sd5);
      run(-16'sd127, 8'sd127);

      // Start pulsed mid-calculation must be ignored
      issue(16'sd15, 8'sd3, 1'b1);
      repeat (3) @(negedge clk);
      chk("busy_mid_calc", busy, 1);
      dividend = 16'sd999; divisor = 8'sd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();

      // Reset during the 5th CALC cycle discards the operation
      issue(16'sd1000, 8'sd7, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_quotient", quotient, 0);
      chk("midrst_remainder", remainder, 0);
      chk("midrst_overflow", overflow, 0);
      chk("midrst_dbz", div_by_zero, 0);
      rst = 1'b0;
      repeat (2*LAT) @(negedge clk);
      run(-16'sd17, 8'sd3);

      // Randomized operands
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0: ra = 16'($urandom);
            1: ra = 16'($signed(8'($urandom)));
            default: ra = 16'($signed(12'($urandom)));
         endcase
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: rb = '1;
            2: rb = 8'h80;
            default: rb = 8'($urandom);
         endcase
         run(ra, rb);
      end

      repeat (3) @(negedge clk);
      chk("pending_results", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
